obi_sram_adapter: RTL and testbench
===================================

# obi_sram_adapter

- Bridges the OBI data/instruction bus to a single-port SRAM bank wrapper, one instance per bank.
- Converts granted OBI requests into single-cycle SRAM accesses and returns a response one cycle later.
- Sequences the bank's power-gate handshake: the bank is drained, gated and woken under power-manager control, and bus requests stall while the bank is not powered.

## Interface
Parameters:
- NumWords, 1024: words in the attached bank.
- AddrWidth, $clog2(NumWords) (min 1): derived word-address width, not overridden.
- WakeCycles, 4: settle cycles after power-up ack before the first grant; 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low; all state is cleared when it is low.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  OBI byte address.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- pwr_off_req_i  in  1  power manager requests bank off.
- retentive_i  in  1  keep contents while off.
- pwr_on_o  out  1  the FSM is in ON.
- sram_req_o  out  1  to the bank.
- sram_we_o  out  1  to the bank.
- sram_addr_o  out  AddrWidth  to the bank.
- sram_wdata_o  out  32  to the bank.
- sram_be_o  out  4  to the bank.
- sram_rdata_i  in  32  from the bank; valid the cycle after the access.
- sram_pwrgate_no  out  1  to the bank, active-low gate.
- sram_pwrgate_ack_ni  in  1  from the bank, active-low ack.
- sram_set_retentive_no  out  1  to the bank, active-low.

## Operation
- FSM states: ON, DRAIN, OFF, WAKE. Reset state is WAKE, with the wake counter at 0.
- ON:
  - gnt_o = req_i, combinational.
  - On a grant, sram_req_o=1. The we/be/wdata signals pass through, and sram_addr_o = addr_i[AddrWidth+1:2].
  - Upper address bits are ignored, so addresses alias modulo the bank size.
  - If pwr_off_req_i=1, no grant is given that cycle and the FSM goes to DRAIN.
- DRAIN:
  - gnt_o=0.
  - Stay for one cycle if a response is outstanding (rvalid pending), then go to OFF.
- OFF:
  - sram_pwrgate_no=0 and gnt_o=0.
  - sram_set_retentive_no = ~retentive_i, registered on OFF entry and held for the rest of OFF.
  - When pwr_off_req_i=0, go to WAKE.
- WAKE:
  - sram_pwrgate_no=1.
  - Once sram_pwrgate_ack_ni=1, the counter increments each cycle.
  - When the counter reaches WakeCycles-1, go to ON.
  - If pwr_off_req_i=1 during WAKE, go directly to OFF.
- Outside OFF, sram_set_retentive_no=1.
- Responses:
  - Each granted access produces exactly one rvalid_o pulse, in the following cycle.
  - For reads, rdata_o = sram_rdata_i. For writes, rdata_o = 0.
  - Whether an access was a read is tracked in a 1-bit pending register plus a 1-bit we register.
- When sram_req_o=0, sram_we_o and sram_be_o are forced to 0.

## Timing
- Outputs while rst_ni is low:
  - gnt_o=0, rvalid_o=0, rdata_o=0, pwr_on_o=0.
  - sram_req_o=0, sram_we_o=0, sram_be_o=0, sram_addr_o=0, sram_wdata_o=0.
  - sram_pwrgate_no=1, sram_set_retentive_no=1.
- Grant has 0-cycle latency. Response latency is exactly 1 cycle.
- Back-to-back: one access per cycle, with rvalid_o high on consecutive cycles.
- Reset asserted mid-access: the pending response is dropped and no rvalid_o is issued after reset.
- pwr_off_req_i and req_i high together in ON: pwr_off_req_i wins and gnt_o=0.
- The ack must be observed high before counting. A missing ack stalls in WAKE indefinitely (no timeout).

## Structure
- Shared package obi_sram_pkg holds:
  - the FSM state enum pwr_state_e (ON, DRAIN, OFF, WAKE);
  - the OBI request/response struct types;
  - WakeCntWidth = 8.
- One sub-module, obi_sram_pwr_fsm: state register, wake counter, pwrgate/retention outputs, and a "grant allowed" output.
- The top level holds the request pass-through and the response register.

## Test plan
- Reset release with ack tied high and WakeCycles=4 → pwr_on_o rises in the 4th cycle after the first ack-high cycle; no gnt_o before that.
- Write 0xDEADBEEF to byte address 0x10 with be=0xF, then read 0x10 → sram_addr_o=4 on both accesses; write rvalid has rdata_o=0; read rvalid has rdata_o=0xDEADBEEF one cycle after its grant.
- Three back-to-back reads with req_i held high → three grants on consecutive cycles and three consecutive rvalid_o pulses, each one cycle after its grant.
- Read to 0x1000 with NumWords=1024 → sram_addr_o=0 (aliasing).
- pwr_off_req_i raised together with req_i, retentive_i=1 → gnt_o=0, then DRAIN, then OFF with sram_pwrgate_no=0 and sram_set_retentive_no=0. Drop pwr_off_req_i → WAKE, then ON after the ack plus WakeCycles.
- rst_ni pulsed low the cycle after a read grant → no rvalid_o, and all outputs at their reset values while rst_ni is low.

Source files
------------

// File: rtl/obi_sram_pkg.sv
// obi_sram_pkg: shared types for the OBI-to-SRAM bank adapter.
// Holds the power FSM state enum, OBI bundles and wake counter width.
package obi_sram_pkg;

    localparam int WakeCntWidth = 8;

    typedef enum logic [1:0] {
        PWR_ON,
        PWR_DRAIN,
        PWR_OFF,
        PWR_WAKE
    } pwr_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/obi_sram_pwr_fsm.sv
// obi_sram_pwr_fsm: bank power sequencing (ON/DRAIN/OFF/WAKE).
// Ports: clk_i, rst_ni, pwr_off_req_i, retentive_i, pending_i,
//   pwrgate_ack_ni in; gnt_allowed_o, pwr_on_o, pwrgate_no,
//   set_retentive_no out.
module obi_sram_pwr_fsm
    import obi_sram_pkg::*;
#(
    parameter int WakeCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_off_req_i,
    input  logic retentive_i,
    input  logic pending_i,
    input  logic pwrgate_ack_ni,
    output logic gnt_allowed_o,
    output logic pwr_on_o,
    output logic pwrgate_no,
    output logic set_retentive_no
);

    localparam logic [WakeCntWidth-1:0] LastCnt =
        WakeCntWidth'(WakeCycles - 1);

    pwr_state_e              state_q, state_d;
    logic [WakeCntWidth-1:0] cnt_q, cnt_d;
    logic                    ret_q, ret_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PWR_WAKE;
            cnt_q   <= '0;
            ret_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ret_d         = ret_q;
        gnt_allowed_o = 1'b0;
        unique case (state_q)
            PWR_ON: begin
                if (pwr_off_req_i) begin
                    state_d = PWR_DRAIN;
                end else begin
                    gnt_allowed_o = 1'b1;
                end
            end
            PWR_DRAIN: begin
                if (!pending_i) begin
                    state_d = PWR_OFF;
                end
            end
            PWR_OFF: begin
                cnt_d = '0;
                if (!pwr_off_req_i) begin
                    state_d = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                // Count only while the bank reports power-good.
                if (pwr_off_req_i) begin
                    state_d = PWR_OFF;
                end else if (pwrgate_ack_ni) begin
                    if (cnt_q == LastCnt) begin
                        state_d = PWR_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = PWR_WAKE;
        endcase
        // Retention choice is latched once, on the way into OFF.
        if (state_d == PWR_OFF && state_q != PWR_OFF) begin
            ret_d = ~retentive_i;
        end
    end

    assign pwr_on_o         = (state_q == PWR_ON);
    assign pwrgate_no       = (state_q != PWR_OFF);
    assign set_retentive_no = (state_q == PWR_OFF) ? ret_q : 1'b1;

endmodule

// File: rtl/obi_sram_adapter.sv
// obi_sram_adapter: OBI slave to single-port SRAM bank, with power gating.
// Ports: OBI req/gnt/addr/we/be/wdata/rvalid/rdata, power manager
//   pwr_off_req/retentive/pwr_on, and the sram_* bank interface.
module obi_sram_adapter
    import obi_sram_pkg::*;
#(
    parameter int NumWords   = 1024,
    parameter int WakeCycles = 4,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    input  logic                 pwr_off_req_i,
    input  logic                 retentive_i,
    output logic                 pwr_on_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    input  logic [31:0]          sram_rdata_i,
    output logic                 sram_pwrgate_no,
    input  logic                 sram_pwrgate_ack_ni,
    output logic                 sram_set_retentive_no
);

    obi_req_t obi_req;
    obi_rsp_t obi_rsp;
    logic     gnt_allowed;
    logic     gnt;
    logic     pend_q, pend_d;
    logic     we_q, we_d;
    logic     unused_addr;

    assign obi_req = '{
        req:   req_i,
        we:    we_i,
        be:    be_i,
        addr:  addr_i,
        wdata: wdata_i
    };

    obi_sram_pwr_fsm #(
        .WakeCycles(WakeCycles)
    ) u_pwr_fsm (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pwr_off_req_i   (pwr_off_req_i),
        .retentive_i     (retentive_i),
        .pending_i       (pend_q),
        .pwrgate_ack_ni  (sram_pwrgate_ack_ni),
        .gnt_allowed_o   (gnt_allowed),
        .pwr_on_o        (pwr_on_o),
        .pwrgate_no      (sram_pwrgate_no),
        .set_retentive_no(sram_set_retentive_no)
    );

    assign gnt = obi_req.req & gnt_allowed;

    // Bank-side signals are zeroed when idle so nothing toggles the macro.
    assign sram_req_o   = gnt;
    assign sram_we_o    = gnt & obi_req.we;
    assign sram_be_o    = gnt ? obi_req.be : '0;
    assign sram_wdata_o = gnt ? obi_req.wdata : '0;
    assign sram_addr_o  = gnt ? obi_req.addr[AddrWidth+1:2] : '0;

    // Upper bits alias; byte offset is covered by be.
    assign unused_addr =
        ^{obi_req.addr[31:AddrWidth+2], obi_req.addr[1:0]};

    assign pend_d = gnt;
    assign we_d   = gnt & obi_req.we;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            we_q   <= we_d;
        end
    end

    assign obi_rsp = '{
        gnt:    gnt,
        rvalid: pend_q,
        rdata:  (pend_q & ~we_q) ? sram_rdata_i : '0
    };

    assign gnt_o    = obi_rsp.gnt;
    assign rvalid_o = obi_rsp.rvalid;
    assign rdata_o  = obi_rsp.rdata;

endmodule

// File: tb/tb_obi_sram_adapter.sv
// tb_obi_sram_adapter: scoreboard bench for obi_sram_adapter.
// Random OBI traffic vs. a word-array model, plus power and reset cases.
module tb_obi_sram_adapter;

    localparam int NW   = 1024;
    localparam int WAKE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  be_i;
    logic        pwr_off, ret_i, ack_n;
    logic        gnt_o, rvalid_o, pwr_on_o;
    logic [31:0] rdata_o;
    logic        sram_req_o, sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata = '0;
    logic        pg_n, ret_n;

    always #5 clk = ~clk;

    obi_sram_adapter #(
        .NumWords  (NW),
        .WakeCycles(WAKE)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_i                (req_i),
        .gnt_o                (gnt_o),
        .addr_i               (addr_i),
        .we_i                 (we_i),
        .be_i                 (be_i),
        .wdata_i              (wdata_i),
        .rvalid_o             (rvalid_o),
        .rdata_o              (rdata_o),
        .pwr_off_req_i        (pwr_off),
        .retentive_i          (ret_i),
        .pwr_on_o             (pwr_on_o),
        .sram_req_o           (sram_req_o),
        .sram_we_o            (sram_we_o),
        .sram_addr_o          (sram_addr_o),
        .sram_wdata_o         (sram_wdata_o),
        .sram_be_o            (sram_be_o),
        .sram_rdata_i         (sram_rdata),
        .sram_pwrgate_no      (pg_n),
        .sram_pwrgate_ack_ni  (ack_n),
        .sram_set_retentive_no(ret_n)
    );

    // Bank model: one-cycle read latency, garbage on non-read cycles.
    logic [31:0] sram_mem [NW] = '{default: '0};
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (sram_be_o[i])
                        sram_mem[sram_addr_o][8*i +: 8] <=
                            sram_wdata_o[8*i +: 8];
                sram_rdata <= 32'hA5A5_5A5A;
            end else begin
                sram_rdata <= sram_mem[sram_addr_o];
            end
        end else begin
            sram_rdata <= $urandom;
        end
    end

    // Reference model: plain word array indexed by byte address / 4.
    logic [31:0] ref_mem [NW] = '{default: '0};

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every rvalid pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid_spurious: got 1 want 0 at cyc %0d",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", rdata_o, e.data);
                chk("rvalid_lat", 32'(cyc), 32'(e.cyc + 1));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL rvalid_missing: got 0 want 1 at cyc %0d", cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One expected-granted access; called and returns at posedge+1.
    task automatic acc(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        int   idx;
        exp_t e;
        idx = int'((a >> 2) % NW);
        req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
        @(negedge clk);
        chk("gnt", 32'(gnt_o), 32'd1);
        chk("sram_req", 32'(sram_req_o), 32'd1);
        chk("sram_addr", 32'(sram_addr_o), 32'(idx));
        chk("sram_we", 32'(sram_we_o), 32'(w));
        chk("sram_be", 32'(sram_be_o), 32'(b));
        chk("sram_wdata", sram_wdata_o, d);
        e.cyc = cyc;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            e.data = '0;
        end else begin
            e.data = ref_mem[idx];
        end
        exp_q.push_back(e);
        step();
        req_i = 1'b0;
    endtask

    task automatic idle();
        req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom;
        be_i = 4'($urandom); wdata_i = $urandom;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt_o), 32'd0);
        chk("idle_sram_req", 32'(sram_req_o), 32'd0);
        chk("idle_sram_we", 32'(sram_we_o), 32'd0);
        chk("idle_sram_be", 32'(sram_be_o), 32'd0);
        step();
    endtask

    task automatic reset_chk();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_pwr_on", 32'(pwr_on_o), 32'd0);
        chk("rst_sram_req", 32'(sram_req_o), 32'd0);
        chk("rst_sram_we", 32'(sram_we_o), 32'd0);
        chk("rst_sram_be", 32'(sram_be_o), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr_o), 32'd0);
        chk("rst_sram_wdata", sram_wdata_o, 32'd0);
        chk("rst_pwrgate_n", 32'(pg_n), 32'd1);
        chk("rst_ret_n", 32'(ret_n), 32'd1);
    endtask

    // From posedge+1 of the first ack-high cycle: WAKE cycles stalled,
    // then ON. req_i is held high to prove no early grant.
    task automatic wake_chk(input string tag);
        req_i = 1'b1; we_i = 1'b0;
        for (int i = 0; i < WAKE; i++) begin
            @(negedge clk);
            chk({tag, "_pwr_on_early"}, 32'(pwr_on_o), 32'd0);
            chk({tag, "_gnt_early"}, 32'(gnt_o), 32'd0);
            step();
        end
        req_i = 1'b0;
        @(negedge clk);
        chk({tag, "_pwr_on"}, 32'(pwr_on_o), 32'd1);
        step();
    endtask

    logic [31:0] ra;

    initial begin
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
        be_i = '0; wdata_i = '0; pwr_off = 1'b0; ret_i = 1'b0;
        ack_n = 1'b1;
        step();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; be_i = 4'hF;
        wdata_i = 32'h1234_5678;
        @(negedge clk);
        reset_chk();
        step();
        rst_n = 1'b1;
        wake_chk("boot");

        acc(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        acc(1'b0, 32'h10, 4'hF, 32'h0);
        idle();
        for (int i = 0; i < 3; i++) acc(1'b0, 32'h10 + 32'(4 * i), 4'hF, '0);
        acc(1'b0, 32'h1000, 4'hF, '0);
        idle();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0)
                acc(1'($urandom), $urandom & 32'hFFFF_F03F,
                    4'($urandom), $urandom);
            else
                idle();
        end

        // Power-off request collides with a bus request.
        acc(1'b0, 32'h10, 4'hF, '0);
        req_i = 1'b1; we_i = 1'b0; pwr_off = 1'b1; ret_i = 1'b1;
        @(negedge clk);
        chk("off_gnt", 32'(gnt_o), 32'd0);
        chk("off_sram_req", 32'(sram_req_o), 32'd0);
        step();
        @(negedge clk);
        chk("drain_pwr_on", 32'(pwr_on_o), 32'd0);
        chk("drain_gnt", 32'(gnt_o), 32'd0);
        chk("drain_pwrgate_n", 32'(pg_n), 32'd1);
        chk("drain_ret_n", 32'(ret_n), 32'd1);
        step();
        ack_n = 1'b0;
        @(negedge clk);
        chk("off_pwrgate_n", 32'(pg_n), 32'd0);
        chk("off_ret_n", 32'(ret_n), 32'd0);
        chk("off_gnt2", 32'(gnt_o), 32'd0);
        step();
        ret_i = 1'b0;
        @(negedge clk);
        chk("off_ret_held", 32'(ret_n), 32'd0);
        step();
        pwr_off = 1'b0;
        @(negedge clk);
        chk("off_last_pwrgate_n", 32'(pg_n), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wake_pwrgate_n", 32'(pg_n), 32'd1);
            chk("wake_ret_n", 32'(ret_n), 32'd1);
            chk("wake_noack_pwr_on", 32'(pwr_on_o), 32'd0);
            chk("wake_noack_gnt", 32'(gnt_o), 32'd0);
            step();
        end
        ack_n = 1'b1;
        wake_chk("rewake");
        acc(1'b0, 32'h10, 4'hF, '0);

        // Reset pulse the cycle after a read grant drops its response.
        ra = 32'h24;
        req_i = 1'b1; we_i = 1'b0; addr_i = ra; be_i = 4'hF;
        @(negedge clk);
        chk("pre_rst_gnt", 32'(gnt_o), 32'd1);
        step();
        rst_n = 1'b0;
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF;
        addr_i = $urandom | 32'h4; wdata_i = $urandom | 32'h1;
        @(negedge clk);
        reset_chk();
        step();
        @(negedge clk);
        reset_chk();
        step();
        rst_n = 1'b1;
        wake_chk("postrst");
        acc(1'b0, ra, 4'hF, '0);
        repeat (3) idle();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
